// File: rtl/mpu_instr_sched.sv
// rtl/mpu_instr_sched.sv - instruction queue and issue scheduler for the MPU control FSM
module mpu_instr_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             host_instruction,
  input  logic                   host_valid,
  output logic                   host_ready,
  output logic [7:0]             fsm_instruction,
  input  logic                   fsm_busy,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   err_timeout,
  output logic [15:0]            issued_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [TW-1:0] r_timer;
  logic          r_err;
  logic [15:0]   r_issued;

  logic          w_is_nop;
  logic          w_push;
  logic          w_pop;
  logic          w_timeout_hit;

  // Acceptance is decided from the registered count only, so a pop in the
  // same cycle never opens a slot early; NOP opcodes are never stored.
  assign host_ready = (r_count < FULL_COUNT);
  assign w_is_nop   = (host_instruction[3:2] == 2'b00);
  assign w_push     = host_valid && host_ready && !w_is_nop && !reset;

  assign q_count      = r_count;
  assign err_timeout  = r_err;
  assign issued_count = r_issued;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic, head presentation and pop/timeout strobes
  always_comb begin
    w_next_state    = r_state;
    w_pop           = 1'b0;
    w_timeout_hit   = 1'b0;
    fsm_instruction = 8'h00;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !fsm_busy) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fsm_instruction = r_mem[r_rd_ptr];
        w_pop           = 1'b1;
        w_next_state    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (fsm_busy) begin
          w_next_state = S_WAIT_DONE;
        end else if (r_timer == TIMER_LAST) begin
          w_timeout_hit = 1'b1;
          w_next_state  = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!fsm_busy) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Queue storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= host_instruction;
    end
  end

  // Circular pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Acknowledge timer runs only while waiting for busy to rise
  always_ff @(posedge clk) begin
    if (reset || (r_state != S_WAIT_BUSY)) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_timeout_hit) begin
      r_err <= 1'b1;
    end
  end

  // Issued-instruction counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issued <= '0;
    end else if (w_pop) begin
      r_issued <= r_issued + 16'd1;
    end
  end

endmodule

// File: tb/tb_mpu_instr_sched.sv
// tb/tb_mpu_instr_sched.sv - scoreboard testbench for mpu_instr_sched
module tb_mpu_instr_sched;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [7:0]             host_instruction;
  logic                   host_valid;
  logic                   host_ready;
  logic [7:0]             fsm_instruction;
  logic                   fsm_busy;
  logic [$clog2(DEPTH):0] q_count;
  logic                   err_timeout;
  logic [15:0]            issued_count;

  logic [7:0] expq [$];
  logic [7:0] obsq [$];
  int         obs_t [$];
  int         cyc;
  int         n_tests;
  int         n_fail;
  int         ack_left;
  int         exp_issued;
  bit         auto_ack;

  mpu_instr_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .host_instruction (host_instruction),
    .host_valid       (host_valid),
    .host_ready       (host_ready),
    .fsm_instruction  (fsm_instruction),
    .fsm_busy         (fsm_busy),
    .q_count          (q_count),
    .err_timeout      (err_timeout),
    .issued_count     (issued_count)
  );

  always #5 clk = ~clk;

  // One clock: record any issue at the falling edge, then advance past the
  // rising edge; optionally play an MPU FSM that answers each issue with busy.
  task automatic step();
    @(negedge clk);
    if (fsm_instruction !== 8'h00) begin
      obsq.push_back(fsm_instruction);
      obs_t.push_back(cyc);
      if (auto_ack) ack_left = 3;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (auto_ack) begin
      if (ack_left > 0) begin
        fsm_busy = 1'b1;
        ack_left--;
      end else begin
        fsm_busy = 1'b0;
      end
    end
  endtask

  task automatic push(input logic [7:0] instr, input bit accept);
    host_instruction = instr;
    host_valid       = 1'b1;
    if (accept) expq.push_back(instr);
    step();
    host_valid       = 1'b0;
    host_instruction = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; host_valid = 1'b1; host_instruction = 8'h1C;
    step(); step();
    reset = 1'b0; host_valid = 1'b0; host_instruction = 8'h00;
    n_tests++; if (q_count !== 0) begin n_fail++; $display("FAIL reset_q_count: got %0d expected 0", q_count); end
    n_tests++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_host_ready: got %b expected 1", host_ready); end
    n_tests++; if (fsm_instruction !== 8'h00) begin n_fail++; $display("FAIL reset_fsm_instr: got %h expected 00", fsm_instruction); end
    n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_timeout); end
    n_tests++; if (issued_count !== 16'd0) begin n_fail++; $display("FAIL reset_issued: got %0d expected 0", issued_count); end
    for (int i = 0; i < 4; i++) step();
    n_tests++; if (obsq.size() != 0) begin n_fail++; $display("FAIL reset_no_issue: got %0d issues expected 0", obsq.size()); end
    obsq.delete(); obs_t.delete(); expq.delete();
  endtask

  task automatic test_single_op();
    int acc;
    logic [7:0] got, want;
    auto_ack = 1'b1; ack_left = 0; fsm_busy = 1'b0;
    push(8'h1C, 1'b1);
    acc = cyc;
    for (int i = 0; i < 12; i++) step();
    exp_issued += 1;
    n_tests++; if (obsq.size() != 1) begin n_fail++; $display("FAIL single_issue_cycles: got %0d expected 1", obsq.size()); end
    if (obs_t.size() > 0) begin
      n_tests++; if (obs_t[0] - acc != 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1", obs_t[0] - acc); end
    end
    while (obsq.size() > 0 && expq.size() > 0) begin
      got = obsq.pop_front(); want = expq.pop_front();
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL single_instr: got %h expected %h", got, want); end
    end
    n_tests++; if (issued_count !== 16'(exp_issued)) begin n_fail++; $display("FAIL single_issued: got %0d expected %0d", issued_count, exp_issued); end
    n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", err_timeout); end
    obsq.delete(); obs_t.delete(); expq.delete();
  endtask

  task automatic test_nop_filter();
    auto_ack = 1'b1; ack_left = 0; fsm_busy = 1'b0;
    push(8'hF3, 1'b0);
    n_tests++; if (q_count !== 0) begin n_fail++; $display("FAIL nop_q_count: got %0d expected 0", q_count); end
    push(8'h42, 1'b0);
    n_tests++; if (q_count !== 0) begin n_fail++; $display("FAIL nop2_q_count: got %0d expected 0", q_count); end
    for (int i = 0; i < 6; i++) step();
    n_tests++; if (obsq.size() != 0) begin n_fail++; $display("FAIL nop_issued: got %0d issues expected 0", obsq.size()); end
    n_tests++; if (issued_count !== 16'(exp_issued)) begin n_fail++; $display("FAIL nop_issued_count: got %0d expected %0d", issued_count, exp_issued); end
    obsq.delete(); obs_t.delete(); expq.delete();
  endtask

  task automatic test_full_queue();
    logic [7:0] got, want;
    auto_ack = 1'b0; ack_left = 0; fsm_busy = 1'b1;
    push(8'h14, 1'b1); push(8'h25, 1'b1); push(8'h36, 1'b1); push(8'h47, 1'b1);
    n_tests++; if (q_count !== 4) begin n_fail++; $display("FAIL full_q_count: got %0d expected 4", q_count); end
    n_tests++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL full_host_ready: got %b expected 0", host_ready); end
    push(8'h58, 1'b0);
    n_tests++; if (q_count !== 4) begin n_fail++; $display("FAIL full_fifth_rejected: got %0d expected 4", q_count); end
    auto_ack = 1'b1; fsm_busy = 1'b0;
    for (int i = 0; i < 80 && obsq.size() < 4; i++) step();
    for (int i = 0; i < 8; i++) step();
    exp_issued += 4;
    n_tests++; if (obsq.size() != expq.size()) begin n_fail++; $display("FAIL full_issue_total: got %0d expected %0d", obsq.size(), expq.size()); end
    while (obsq.size() > 0 && expq.size() > 0) begin
      got = obsq.pop_front(); want = expq.pop_front();
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL full_order: got %h expected %h", got, want); end
    end
    n_tests++; if (issued_count !== 16'(exp_issued)) begin n_fail++; $display("FAIL full_issued: got %0d expected %0d", issued_count, exp_issued); end
    n_tests++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL full_drained_ready: got %b expected 1", host_ready); end
    obsq.delete(); obs_t.delete(); expq.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, want;
    auto_ack = 1'b0; ack_left = 0; fsm_busy = 1'b1;
    push(8'h65, 1'b1); push(8'h7A, 1'b1);
    auto_ack = 1'b1; fsm_busy = 1'b0;
    step();
    n_tests++; if (q_count !== 2) begin n_fail++; $display("FAIL b2b_before: got %0d expected 2", q_count); end
    push(8'h8E, 1'b1);
    n_tests++; if (q_count !== 2) begin n_fail++; $display("FAIL b2b_push_pop: got %0d expected 2", q_count); end
    for (int i = 0; i < 80 && obsq.size() < 3; i++) step();
    for (int i = 0; i < 8; i++) step();
    exp_issued += 3;
    n_tests++; if (obsq.size() != expq.size()) begin n_fail++; $display("FAIL b2b_issue_total: got %0d expected %0d", obsq.size(), expq.size()); end
    while (obsq.size() > 0 && expq.size() > 0) begin
      got = obsq.pop_front(); want = expq.pop_front();
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL b2b_order: got %h expected %h", got, want); end
    end
    n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b expected 0", err_timeout); end
    n_tests++; if (issued_count !== 16'(exp_issued)) begin n_fail++; $display("FAIL b2b_issued: got %0d expected %0d", issued_count, exp_issued); end
    obsq.delete(); obs_t.delete(); expq.delete();
  endtask

  task automatic test_timeout();
    int err_cyc;
    logic [7:0] got, want;
    auto_ack = 1'b0; ack_left = 0; fsm_busy = 1'b0;
    push(8'h04, 1'b1); push(8'h38, 1'b1);
    n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", err_timeout); end
    err_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (err_timeout === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end
    exp_issued += 2;
    n_tests++; if (obs_t.size() != 2) begin n_fail++; $display("FAIL timeout_issue_total: got %0d expected 2", obs_t.size()); end
    if (obs_t.size() >= 2) begin
      n_tests++; if (err_cyc != obs_t[0] + 1 + TIMEOUT) begin n_fail++; $display("FAIL timeout_when: got cycle %0d expected %0d", err_cyc, obs_t[0] + 1 + TIMEOUT); end
      n_tests++; if (obs_t[1] != obs_t[0] + 2 + TIMEOUT) begin n_fail++; $display("FAIL timeout_next_issue: got cycle %0d expected %0d", obs_t[1], obs_t[0] + 2 + TIMEOUT); end
    end
    while (obsq.size() > 0 && expq.size() > 0) begin
      got = obsq.pop_front(); want = expq.pop_front();
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL timeout_order: got %h expected %h", got, want); end
    end
    n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", err_timeout); end
    n_tests++; if (issued_count !== 16'(exp_issued)) begin n_fail++; $display("FAIL timeout_issued: got %0d expected %0d", issued_count, exp_issued); end
    obsq.delete(); obs_t.delete(); expq.delete();
  endtask

  task automatic test_handshake();
    int fall;
    logic [7:0] got, want;
    auto_ack = 1'b0; ack_left = 0; fsm_busy = 1'b0;
    push(8'h0F, 1'b1); push(8'h2A, 1'b1);
    fsm_busy = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_tests++; if (obsq.size() != 1) begin n_fail++; $display("FAIL hs_during_busy: got %0d issues expected 1", obsq.size()); end
    fsm_busy = 1'b0;
    fall = cyc;
    for (int i = 0; i < 20 && obsq.size() < 2; i++) step();
    for (int i = 0; i < 8; i++) step();
    exp_issued += 2;
    if (obs_t.size() >= 2) begin
      n_tests++; if (obs_t[1] != fall + 2) begin n_fail++; $display("FAIL hs_next_issue: got cycle %0d expected %0d", obs_t[1], fall + 2); end
    end
    n_tests++; if (obsq.size() != expq.size()) begin n_fail++; $display("FAIL hs_issue_total: got %0d expected %0d", obsq.size(), expq.size()); end
    while (obsq.size() > 0 && expq.size() > 0) begin
      got = obsq.pop_front(); want = expq.pop_front();
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL hs_order: got %h expected %h", got, want); end
    end
    n_tests++; if (issued_count !== 16'(exp_issued)) begin n_fail++; $display("FAIL hs_issued: got %0d expected %0d", issued_count, exp_issued); end
    obsq.delete(); obs_t.delete(); expq.delete();
  endtask

  task automatic test_mid_reset();
    logic [7:0] got, want;
    auto_ack = 1'b0; ack_left = 0; fsm_busy = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    exp_issued = 0;
    n_tests++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL mid_err_cleared: got %b expected 0", err_timeout); end
    n_tests++; if (issued_count !== 16'd0) begin n_fail++; $display("FAIL mid_issued_cleared: got %0d expected 0", issued_count); end
    fsm_busy = 1'b1;
    push(8'h15, 1'b1); push(8'h26, 1'b1); push(8'h39, 1'b1); push(8'h4D, 1'b1);
    fsm_busy = 1'b0;
    step(); step();
    fsm_busy = 1'b1;
    step();
    n_tests++; if (q_count !== 3) begin n_fail++; $display("FAIL mid_before_reset: got %0d expected 3", q_count); end
    reset = 1'b1; host_valid = 1'b1; host_instruction = 8'h5C;
    step();
    reset = 1'b0; host_valid = 1'b0; host_instruction = 8'h00;
    while (expq.size() > 1) void'(expq.pop_back());
    n_tests++; if (q_count !== 0) begin n_fail++; $display("FAIL mid_q_count: got %0d expected 0", q_count); end
    n_tests++; if (fsm_instruction !== 8'h00) begin n_fail++; $display("FAIL mid_fsm_instr: got %h expected 00", fsm_instruction); end
    n_tests++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL mid_host_ready: got %b expected 1", host_ready); end
    n_tests++; if (issued_count !== 16'd0) begin n_fail++; $display("FAIL mid_issued: got %0d expected 0", issued_count); end
    fsm_busy = 1'b0;
    for (int i = 0; i < 8; i++) step();
    n_tests++; if (obsq.size() != expq.size()) begin n_fail++; $display("FAIL mid_issue_total: got %0d expected %0d", obsq.size(), expq.size()); end
    while (obsq.size() > 0 && expq.size() > 0) begin
      got = obsq.pop_front(); want = expq.pop_front();
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL mid_order: got %h expected %h", got, want); end
    end
    n_tests++; if (issued_count !== 16'd0) begin n_fail++; $display("FAIL mid_idle_after: got %0d expected 0", issued_count); end
    obsq.delete(); obs_t.delete(); expq.delete();
  endtask

  initial begin
    reset = 1'b1; host_valid = 1'b0; host_instruction = 8'h00; fsm_busy = 1'b0;
    auto_ack = 1'b0; ack_left = 0; cyc = 0; n_tests = 0; n_fail = 0; exp_issued = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_op();
    test_nop_filter();
    test_full_queue();
    test_back_to_back();
    test_timeout();
    test_handshake();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu_instr_sched.md
MPU_INSTR_SCHED -- requirements
Module: mpu_instr_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 4: maximum cycles to wait for fsm_busy to rise after an issue.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port host_instruction, input, 8: host opcode {DD[7:6], AA[5:4], OP[3:0]}.
REQ-006 SHALL have port host_valid, input, 1: host_instruction is valid this cycle.
REQ-007 SHALL have port host_ready, output, 1: the queue can accept an instruction this cycle.
REQ-008 SHALL have port fsm_instruction, output, 8: opcode driven to the MPU control FSM.
REQ-009 SHALL have port fsm_busy, input, 1: busy flag from the MPU control FSM.
REQ-010 SHALL have port q_count, output, $clog2(DEPTH)+1: number of queued entries.
REQ-011 SHALL have port err_timeout, output, 1: sticky flag, set when an issue is not acknowledged.
REQ-012 SHALL have port issued_count, output, 16: count of issued instructions.

Function
REQ-013 SHALL compute host_ready = (q_count < DEPTH); host_ready SHALL NOT depend on a same-cycle pop.
REQ-014 SHALL enqueue host_instruction on a clock edge only when host_valid && host_ready && OP[3:2] != 2'b00.
REQ-015 SHALL silently drop NOP opcodes (OP[3:2] == 00); a dropped NOP SHALL NOT change q_count.
REQ-016 SHALL use a circular FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-017 SHALL implement four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-018 SHALL transition IDLE -> ISSUE when q_count > 0 && fsm_busy == 0; otherwise it SHALL remain in IDLE.
REQ-019 SHALL drive fsm_instruction = queue head for exactly one cycle, while in ISSUE.
REQ-020 SHALL drive fsm_instruction = 8'h00 in every state other than ISSUE.
REQ-021 SHALL, on leaving ISSUE, pop the head, increment issued_count (wrapping at 16 bits), and go to WAIT_BUSY.
REQ-022 SHALL, in WAIT_BUSY, go to WAIT_DONE when fsm_busy == 1.
REQ-023 SHALL, in WAIT_BUSY, set err_timeout and go to IDLE when TIMEOUT cycles elapse with fsm_busy == 0.
REQ-024 SHALL, in WAIT_DONE, go to IDLE when fsm_busy == 0; there SHALL be no timeout in WAIT_DONE.
REQ-025 SHALL apply both operations in the same edge on a simultaneous push and pop; q_count SHALL then be unchanged.
REQ-026 SHALL give a minimum latency of 1 cycle from the accept edge to ISSUE, with an empty queue and an idle FSM.
REQ-027 SHALL hold err_timeout at 1 until reset once set.
REQ-028 SHALL preserve queue order: instructions SHALL issue strictly FIFO, with no reordering.

Reset
REQ-029 SHALL, with reset high at a clock edge, set: state = IDLE, pointers = 0, q_count = 0, fsm_instruction = 8'h00, err_timeout = 0, issued_count = 0.
REQ-030 SHALL, with reset high at a clock edge, force host_ready = 1 from the following cycle.
REQ-031 SHALL, when reset is asserted mid-operation (any state), discard all queued entries and abandon any in-flight wait.
REQ-032 SHALL ignore host_valid in any cycle where reset is high.

Verification
REQ-033 Single op: push 8'h1C to an empty queue with fsm_busy = 0 -> fsm_instruction = 8'h1C for one cycle, one cycle after accept; issued_count = 1.
REQ-034 NOP filter: push 8'hF3 -> q_count stays 0 and fsm_instruction stays 8'h00.
REQ-035 Full queue: hold fsm_busy = 1, push 5 instructions -> q_count = 4, host_ready = 0, 5th not accepted; release busy -> the 4 issue in order.
REQ-036 Timeout: issue 8'h04 with fsm_busy held 0 -> err_timeout = 1 after 4 WAIT_BUSY cycles; the next entry still issues.
REQ-037 Handshake: issue 8'h0F, busy high 10 cycles then low -> the next issue occurs no earlier than 1 cycle after busy falls.
REQ-038 Mid-operation reset: reset in WAIT_DONE with q_count = 3 -> next cycle q_count = 0, state IDLE, fsm_instruction = 8'h00.
